add6_seq_arbiter: RTL
=====================

# add6_seq_arbiter

Bit-serial sequencer for the 6-bit adder datapath, built on the per-bit generate/propagate/half-sum cell (g = x&y, p = x|y, h = x^y). Two requesters share one serial adder through round-robin arbitration. The block resolves one bit per clock, keeps the ripple carry in a register, and returns the sum on a response channel with a valid/ready handshake. It sits between the operand sources and the result consumer, in place of a parallel ripple chain where area matters more than latency.

## Interface
- WIDTH, 6, operand width in bits; also the number of RUN cycles; must be ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands (unsigned or two's complement)
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as the requester 0 ports, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- rsp_cout  out  1  carry out of the MSB
- rsp_id  out  1  index of the requester that owns the result
- rsp_ovf  out  1  signed overflow; present only with ADD6_SEQ_OVF_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - grant = ptr if req[ptr]_valid, else the other requester if its valid is high, else none.
  - req*_ready is combinational: high only for the granted requester, and only in IDLE.
  - On handshake: latch a, b and cin into the carry register; latch id; clear idx and the sum register; go to RUN.
- RUN, with x = a[idx] and y = b[idx]:
  - sum[idx] ← (x^y) ^ c
  - c ← (x&y) | ((x|y) & c)
  - idx ← idx+1
  - After idx = WIDTH-1 is processed, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id come from registers and stay stable.
  - On rsp_valid & rsp_ready: ptr ← ~id (the last winner loses the next tie); go to IDLE.
- Both requesters valid in the same IDLE cycle: only one is granted, per ptr. The loser keeps valid high and is served after the current response retires.
- Requesters must hold operands stable while valid & ~ready. Withdrawing valid before ready is tolerated: arbitration is re-evaluated every IDLE cycle.
- No req*_ready is asserted in RUN or DONE. There is no pipelining: one operation is in flight at a time.
- idx is a ceil(log2(WIDTH))-bit counter that never wraps past WIDTH-1.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, ptr=0, idx=0, c=0, sum=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_ovf=0, req*_ready=0.
- Request accepted at edge T: RUN occupies cycles T+1…T+WIDTH, and rsp_valid rises in cycle T+WIDTH+1 (cycle 7 for WIDTH=6).
- Response retired at edge R: back in IDLE at R+1; the next accept is possible at edge R+1.
- Minimum issue interval: WIDTH+2 cycles.
- rsp_ready held low: the block stays in DONE indefinitely with outputs unchanged.
- rst_n asserted mid-RUN or mid-DONE: the operation is discarded and no response is produced. After release, ptr=0.

## Configuration
- ADD6_SEQ_OVF_EN defined:
  - rsp_ovf port exists.
  - rsp_ovf = (carry into bit WIDTH-1) XOR rsp_cout.
  - The carry into the MSB is captured in a dedicated flop during the last RUN cycle.
- Not defined:
  - rsp_ovf port and its flop are absent.
  - All other behaviour is identical.

## Test plan
- Basic add: req0 a=0x2A, b=0x15, cin=0, accepted at T → rsp_valid at T+7 with sum=0x3F, cout=0, id=0.
- Carry chain: req1 a=0x3F, b=0x00, cin=1 → sum=0x00, cout=1, id=1. With ADD6_SEQ_OVF_EN, ovf=0.
- Overflow (macro on): a=0x1F, b=0x01, cin=0 → sum=0x20, cout=0, ovf=1. Also a=0x20, b=0x20 → sum=0x00, cout=1, ovf=1.
- Arbitration: after reset, both valid in the same cycle with distinct operands. Required order: req0 is served first, then req1; req1_ready stays low until req0's response retires. Repeat with both valid → req0 again, since ptr alternates.
- Backpressure: rsp_ready low for 5 cycles in DONE → rsp_sum, rsp_cout and rsp_id remain constant, and no req*_ready pulse occurs. Raising rsp_ready → IDLE on the next cycle.
- Reset mid-RUN: assert rst_n=0 at the third RUN cycle → all outputs are 0 immediately. After release: no stale rsp_valid, and a fresh request completes correctly.

Source files
------------

// File: rtl/add6_seq_arbiter_if.sv
// add6_seq_arbiter_if: request/response bundle for the bit-serial adder.
// The master side holds the two requesters and the result consumer. The
// slave side is the sequencer. ADD6_SEQ_OVF_EN adds the rsp_ovf signal.
interface add6_seq_arbiter_if #(parameter int WIDTH = 6);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_id;
`ifdef ADD6_SEQ_OVF_EN
  logic             rsp_ovf;
`endif

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADD6_SEQ_OVF_EN
    , input rsp_ovf
`endif
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id
`ifdef ADD6_SEQ_OVF_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/add6_seq_arbiter.sv
// add6_seq_arbiter: two requesters share one bit-serial adder under
// round-robin arbitration. One bit is resolved per clock, and the ripple carry
// is kept in a register. Optional macro ADD6_SEQ_OVF_EN adds the rsp_ovf
// signed-overflow output.
//
// Handshake: a transfer happens on any rising edge where valid & ready are
// both high. A requester holds its operands stable while valid & ~ready. The
// response stays stable while rsp_valid & ~rsp_ready. Only one operation is
// in flight at a time. req*_ready is asserted only in IDLE.
module add6_seq_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  add6_seq_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic [IW-1:0]    idx;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id;
`ifdef ADD6_SEQ_OVF_EN
  logic             ovf;
`endif

  logic gnt0;
  logic gnt1;
  logic x;
  logic y;
  logic g;
  logic p;
  logic h;
  logic c_next;
  logic s_bit;

  // Round-robin grant: ptr has priority, and the other requester wins only when ptr is idle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (ptr) begin
        gnt1 = bus.req1_valid;
        gnt0 = bus.req0_valid & ~bus.req1_valid;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid & ~bus.req0_valid;
      end
    end
  end

  // Per-bit generate/propagate/half-sum cell on the current bit position.
  always_comb begin
    x      = a_q[idx];
    y      = b_q[idx];
    g      = x & y;
    p      = x | y;
    h      = x ^ y;
    c_next = g | (p & c);
    s_bit  = h ^ c;
  end

  // Ready is held low during reset so no handshake is advertised while flops are held.
  assign bus.req0_ready = gnt0 & rst_n;
  assign bus.req1_ready = gnt1 & rst_n;
  assign bus.rsp_valid  = (state == DONE);
  assign bus.rsp_sum    = sum;
  assign bus.rsp_cout   = c;
  assign bus.rsp_id     = id;
`ifdef ADD6_SEQ_OVF_EN
  assign bus.rsp_ovf    = ovf;
`endif
  assign dbg_state      = state;

  // Sequencer: accept in IDLE, one sum bit per RUN cycle, hold the result in DONE until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      idx   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id    <= 1'b0;
`ifdef ADD6_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            a_q   <= gnt1 ? bus.req1_a   : bus.req0_a;
            b_q   <= gnt1 ? bus.req1_b   : bus.req0_b;
            c     <= gnt1 ? bus.req1_cin : bus.req0_cin;
            id    <= gnt1;
            idx   <= '0;
            sum   <= '0;
`ifdef ADD6_SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx] <= s_bit;
          c        <= c_next;
          if (idx == LAST) begin
`ifdef ADD6_SEQ_OVF_EN
            // c is the carry into the MSB here and c_next is the carry out of it.
            ovf   <= c ^ c_next;
`endif
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            // The winner just retired, so the other requester takes the next tie.
            ptr   <= ~id;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
